// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
// Optional build macro RF_ARB_FWD_EN enables writeback-to-read forwarding.
package rf_arb_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int XLEN_DEFAULT = 64;

  typedef struct packed {
    logic [REG_IDX_W-1:0]    rd;
    logic [XLEN_DEFAULT-1:0] value;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_RD
  } grant_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Writeback FIFO with wrap-bit pointers; every entry is exposed oldest-first
// for the parallel hazard compare. RF_ARB_FWD_EN also exposes entry values.
module rf_wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           push_i,
  input  logic [REG_IDX_W-1:0]           push_rd_i,
  input  logic [XLEN-1:0]                push_value_i,
  input  logic                           pop_i,
  output logic                           ready_o,
  output logic                           empty_o,
  output logic [DEPTH-1:0]               ent_valid_o,
  output logic [DEPTH-1:0][REG_IDX_W-1:0] ent_rd_o,
  output logic [XLEN-1:0]                head_value_o
`ifdef RF_ARB_FWD_EN
  ,
  output logic [DEPTH-1:0][XLEN-1:0]     ent_value_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          count, count_d;
  logic                 ready_q;
  logic [REG_IDX_W-1:0] rd_mem  [DEPTH];
  logic [XLEN-1:0]      val_mem [DEPTH];
  logic [AW-1:0]        idx     [DEPTH];

  assign count    = wr_ptr_q - rd_ptr_q;
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_i);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop_i);
  assign count_d  = wr_ptr_d - rd_ptr_d;
  assign empty_o  = (count == '0);
  assign ready_o  = ready_q;

  // Ready is registered from the next-state occupancy, so it reads 0 while full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ready_q  <= (count_d != (AW+1)'(DEPTH));
    end
  end

  // NOTE: storage is not reset; validity comes only from the pointers, so a
  // reset needs no clearing of the entries themselves.
  always_ff @(posedge i_clk) begin
    if (push_i) begin
      rd_mem[wr_ptr_q[AW-1:0]]  <= push_rd_i;
      val_mem[wr_ptr_q[AW-1:0]] <= push_value_i;
    end
  end

  always_comb begin
    ent_valid_o = '0;
    ent_rd_o    = '0;
`ifdef RF_ARB_FWD_EN
    ent_value_o = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx[k]         = rd_ptr_q[AW-1:0] + AW'(k);
      ent_valid_o[k] = ((AW+1)'(k) < count);
      ent_rd_o[k]    = rd_mem[idx[k]];
`ifdef RF_ARB_FWD_EN
      ent_value_o[k] = val_mem[idx[k]];
`endif
    end
    head_value_o = val_mem[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Lossless arbiter for the single-access RF port: buffered writebacks, RAW
// hazard stall, bounded writeback streak. Macro RF_ARB_FWD_EN adds forwarding.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int XLEN          = XLEN_DEFAULT,
  parameter int WB_DEPTH      = 4,
  parameter int MAX_WB_STREAK = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rd_valid,
  output logic                 o_rd_ready,
  input  logic [REG_IDX_W-1:0] i_rd_rs1,
  input  logic [REG_IDX_W-1:0] i_rd_rs2,
  output logic                 o_rsp_valid,
  output logic [XLEN-1:0]      o_rsp_rs1_value,
  output logic [XLEN-1:0]      o_rsp_rs2_value,
  input  logic                 i_wb_valid,
  output logic                 o_wb_ready,
  input  logic [REG_IDX_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]      i_wb_value,
  output logic                 o_rf_we,
  output logic [REG_IDX_W-1:0] o_rf_waddr,
  output logic [XLEN-1:0]      o_rf_wdata,
  output logic                 o_rf_re,
  output logic [REG_IDX_W-1:0] o_rf_raddr1,
  output logic [REG_IDX_W-1:0] o_rf_raddr2,
  input  logic [XLEN-1:0]      i_rf_rdata1,
  input  logic [XLEN-1:0]      i_rf_rdata2,
  output logic                 o_busy
);

  localparam int SW = $clog2(MAX_WB_STREAK + 1);

  logic                              push, fifo_empty, fifo_ready;
  logic [WB_DEPTH-1:0]               ent_valid;
  logic [WB_DEPTH-1:0][REG_IDX_W-1:0] ent_rd;
  logic [XLEN-1:0]                   head_value;
  logic                              run_q, rsp_valid_q;
  logic [SW-1:0]                     streak_q, streak_d;
  logic                              hazard, rd_eligible, rd_urgent;
  logic [XLEN-1:0]                   rsp1, rsp2;
  grant_e                            grant;

  // rd==0 is handshaked but never stored, so x0 can never hazard.
  assign push = i_wb_valid && fifo_ready && (i_wb_rd != '0);

`ifdef RF_ARB_FWD_EN
  logic [WB_DEPTH-1:0][XLEN-1:0] ent_value;
`endif

  rf_wb_fifo #(
    .DEPTH (WB_DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .push_i       (push),
    .push_rd_i    (i_wb_rd),
    .push_value_i (i_wb_value),
    .pop_i        (o_rf_we),
    .ready_o      (fifo_ready),
    .empty_o      (fifo_empty),
    .ent_valid_o  (ent_valid),
    .ent_rd_o     (ent_rd),
    .head_value_o (head_value)
`ifdef RF_ARB_FWD_EN
    ,
    .ent_value_o  (ent_value)
`endif
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (ent_valid[k] && (ent_rd[k] != '0) &&
          ((ent_rd[k] == i_rd_rs1) || (ent_rd[k] == i_rd_rs2)))
        hazard = 1'b1;
    end
  end

`ifdef RF_ARB_FWD_EN
  // A hazarded read is served immediately from the youngest matching entry.
  assign rd_eligible = run_q && i_rd_valid;
  assign rd_urgent   = run_q && i_rd_valid && hazard;
`else
  assign rd_eligible = run_q && i_rd_valid && !hazard;
  assign rd_urgent   = 1'b0;
`endif

  always_comb begin
    grant = GNT_NONE;
    if (rd_urgent)
      grant = GNT_RD;
    else if (!fifo_empty && ((streak_q < SW'(MAX_WB_STREAK)) || !rd_eligible))
      grant = GNT_WB;
    else if (rd_eligible)
      grant = GNT_RD;
  end

  always_comb begin
    streak_d = streak_q;
    if (!i_rd_valid)
      streak_d = '0;
    else if (grant == GNT_WB && streak_q != SW'(MAX_WB_STREAK))
      streak_d = streak_q + SW'(1);
    else if (grant == GNT_RD)
      streak_d = '0;
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q       <= 1'b0;
      streak_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      streak_q    <= streak_d;
      rsp_valid_q <= (grant == GNT_RD);
    end
  end

`ifdef RF_ARB_FWD_EN
  logic            fwd1_hit, fwd2_hit, fwd1_sel_q, fwd2_sel_q;
  logic [XLEN-1:0] fwd1_val, fwd2_val, fwd1_q, fwd2_q;

  // Oldest-to-youngest scan: the last match wins, i.e. the youngest value.
  always_comb begin
    fwd1_hit = 1'b0;
    fwd2_hit = 1'b0;
    fwd1_val = '0;
    fwd2_val = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (ent_valid[k] && (i_rd_rs1 != '0) && (ent_rd[k] == i_rd_rs1)) begin
        fwd1_hit = 1'b1;
        fwd1_val = ent_value[k];
      end
      if (ent_valid[k] && (i_rd_rs2 != '0) && (ent_rd[k] == i_rd_rs2)) begin
        fwd2_hit = 1'b1;
        fwd2_val = ent_value[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fwd1_sel_q <= 1'b0;
      fwd2_sel_q <= 1'b0;
      fwd1_q     <= '0;
      fwd2_q     <= '0;
    end else begin
      fwd1_sel_q <= (grant == GNT_RD) && fwd1_hit;
      fwd2_sel_q <= (grant == GNT_RD) && fwd2_hit;
      fwd1_q     <= fwd1_val;
      fwd2_q     <= fwd2_val;
    end
  end

  assign rsp1 = fwd1_sel_q ? fwd1_q : i_rf_rdata1;
  assign rsp2 = fwd2_sel_q ? fwd2_q : i_rf_rdata2;
`else
  assign rsp1 = i_rf_rdata1;
  assign rsp2 = i_rf_rdata2;
`endif

  assign o_rf_we         = (grant == GNT_WB);
  assign o_rf_waddr      = o_rf_we ? ent_rd[0] : '0;
  assign o_rf_wdata      = o_rf_we ? head_value : '0;
  assign o_rf_re         = (grant == GNT_RD);
  assign o_rd_ready      = o_rf_re;
  assign o_rf_raddr1     = o_rf_re ? i_rd_rs1 : '0;
  assign o_rf_raddr2     = o_rf_re ? i_rd_rs2 : '0;
  assign o_wb_ready      = fifo_ready;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_rs1_value = rsp_valid_q ? rsp1 : '0;
  assign o_rsp_rs2_value = rsp_valid_q ? rsp2 : '0;
  assign o_busy          = !fifo_empty || rsp_valid_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter: vector table plus streak/full/reset sequences.
module tb_rf_port_arbiter;

  localparam int XLEN = 64;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_rd_valid = 1'b0;
  logic [4:0]      i_rd_rs1 = '0, i_rd_rs2 = '0;
  logic            i_wb_valid = 1'b0;
  logic [4:0]      i_wb_rd = '0;
  logic [XLEN-1:0] i_wb_value = '0;
  logic [XLEN-1:0] i_rf_rdata1, i_rf_rdata2;
  logic            o_rd_ready, o_rsp_valid, o_wb_ready, o_rf_we, o_rf_re, o_busy;
  logic [XLEN-1:0] o_rsp_rs1_value, o_rsp_rs2_value, o_rf_wdata;
  logic [4:0]      o_rf_waddr, o_rf_raddr1, o_rf_raddr2;

  always #5 i_clk = ~i_clk;

  rf_port_arbiter #(.XLEN(XLEN), .WB_DEPTH(4), .MAX_WB_STREAK(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready),
    .i_rd_rs1(i_rd_rs1), .i_rd_rs2(i_rd_rs2),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rs1_value(o_rsp_rs1_value), .o_rsp_rs2_value(o_rsp_rs2_value),
    .i_wb_valid(i_wb_valid), .o_wb_ready(o_wb_ready), .i_wb_rd(i_wb_rd), .i_wb_value(i_wb_value),
    .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_rf_re(o_rf_re), .o_rf_raddr1(o_rf_raddr1), .o_rf_raddr2(o_rf_raddr2),
    .i_rf_rdata1(i_rf_rdata1), .i_rf_rdata2(i_rf_rdata2), .o_busy(o_busy)
  );

  // Register-file macro: registered read data, x0 reads as zero.
  logic [XLEN-1:0] rf [32];
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= (i == 3) ? 64'h11 : (i == 5) ? 64'h22 : (i == 0) ? 64'h0 : 64'h100 + 64'(i);
      i_rf_rdata1 <= '0;
      i_rf_rdata2 <= '0;
    end else begin
      if (o_rf_we) rf[o_rf_waddr] <= o_rf_wdata;
      if (o_rf_re) begin
        i_rf_rdata1 <= (o_rf_raddr1 == 5'd0) ? '0 : rf[o_rf_raddr1];
        i_rf_rdata2 <= (o_rf_raddr2 == 5'd0) ? '0 : rf[o_rf_raddr2];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Writeback scoreboard: RF writes must match accepted writebacks in order.
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
  } wb_t;
  wb_t sb[$];

  task automatic sample();
    #1;
    check("port_exclusive", {o_rf_we, o_rf_re} == 2'b11, 1'b0);
    if (o_rf_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write: waddr %0d with no queued writeback", o_rf_waddr);
      end else begin
        check("sb_waddr", o_rf_waddr, sb[0].rd);
        check("sb_wdata", o_rf_wdata, sb[0].value);
        void'(sb.pop_front());
      end
    end
    if (i_wb_valid && o_wb_ready && i_wb_rd != 5'd0)
      sb.push_back(wb_t'{i_wb_rd, i_wb_value});
  endtask

  typedef struct {
    logic            rv;
    logic [4:0]      rs1, rs2;
    logic            wv;
    logic [4:0]      wrd;
    logic [XLEN-1:0] wval;
    logic            e_rdy, e_we;
    logic [4:0]      e_waddr;
    logic [XLEN-1:0] e_wdata;
    logic            e_rsp;
    logic [XLEN-1:0] e_r1, e_r2;
    logic            e_busy;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic wv, input logic [4:0] wrd, input logic [63:0] wval,
                              input logic e_rdy, input logic e_we, input logic [4:0] e_waddr,
                              input logic [63:0] e_wdata, input logic e_rsp,
                              input logic [63:0] e_r1, input logic [63:0] e_r2, input logic e_busy);
    vec_t v;
    v.rv = rv; v.rs1 = rs1; v.rs2 = rs2; v.wv = wv; v.wrd = wrd; v.wval = wval;
    v.e_rdy = e_rdy; v.e_we = e_we; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_rsp = e_rsp; v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_busy = e_busy;
    return v;
  endfunction

  int rds [8] = '{1, 2, 4, 6, 9, 10, 11, 12};
  int push_k = 0;

  // Continuous non-hazard read of x7/x8 while writebacks stream in; starting
  // from empty with streak 0, the grants repeat RD,WB,WB,WB.
  task automatic stream(input int n, input int full_cycle);
    for (int c = 0; c < n; c++) begin
      i_rd_valid = 1'b1; i_rd_rs1 = 5'd7; i_rd_rs2 = 5'd8;
      i_wb_valid = 1'b1; i_wb_rd = 5'(rds[push_k % 8]); i_wb_value = 64'hC0DE_0000 + 64'(push_k);
      sample();
      check($sformatf("stream_rd_grant[%0d]", c), o_rd_ready, (c % 4) == 0);
      check($sformatf("stream_wb_grant[%0d]", c), o_rf_we, (c % 4) != 0);
      check($sformatf("stream_wb_ready[%0d]", c), o_wb_ready, c != full_cycle);
      check($sformatf("stream_rsp_valid[%0d]", c), o_rsp_valid, (c > 0) && ((c - 1) % 4 == 0));
      if (c > 0 && (c - 1) % 4 == 0) begin
        check($sformatf("stream_rsp1[%0d]", c), o_rsp_rs1_value, 64'h107);
        check($sformatf("stream_rsp2[%0d]", c), o_rsp_rs2_value, 64'h108);
      end
      if (o_wb_ready) push_k++;
      @(negedge i_clk);
    end
  endtask

  task automatic idle_inputs();
    i_rd_valid = 1'b0; i_rd_rs1 = '0; i_rd_rs2 = '0;
    i_wb_valid = 1'b0; i_wb_rd = '0; i_wb_value = '0;
  endtask

  vec_t tbl [17];

  initial begin
    tbl[0]  = mk(0, 0, 0,  0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0);
    tbl[1]  = mk(1, 3, 5,  0, 0, 0,      1, 0, 0, 0,      0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,  0, 0, 0,      0, 0, 0, 0,      1, 64'h11, 64'h22, 1);
    tbl[3]  = mk(0, 0, 0,  1, 3, 64'hAA, 0, 0, 0, 0,      0, 0, 0, 0);
    tbl[4]  = mk(1, 3, 5,  0, 0, 0,      0, 1, 3, 64'hAA, 0, 0, 0, 1);
    tbl[5]  = mk(1, 3, 5,  0, 0, 0,      1, 0, 0, 0,      0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,  0, 0, 0,      0, 0, 0, 0,      1, 64'hAA, 64'h22, 1);
    tbl[7]  = mk(0, 0, 0,  1, 0, 64'hFF, 0, 0, 0, 0,      0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 5,  0, 0, 0,      1, 0, 0, 0,      0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0,  0, 0, 0,      0, 0, 0, 0,      1, 64'h0, 64'h22, 1);
    tbl[10] = mk(0, 0, 0,  1, 5, 64'hBB, 0, 0, 0, 0,      0, 0, 0, 0);
    tbl[11] = mk(1, 9, 5,  0, 0, 0,      0, 1, 5, 64'hBB, 0, 0, 0, 1);
    tbl[12] = mk(1, 9, 5,  0, 0, 0,      1, 0, 0, 0,      0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0,  0, 0, 0,      0, 0, 0, 0,      1, 64'h109, 64'hBB, 1);
    tbl[14] = mk(1, 9, 10, 1, 9, 64'hCC, 1, 0, 0, 0,      0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0,  0, 0, 0,      0, 1, 9, 64'hCC, 1, 64'h109, 64'h10A, 1);
    tbl[16] = mk(0, 0, 0,  0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0);

    // Reset state.
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_wb_ready", o_wb_ready, 1'b0);
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_rf_we", o_rf_we, 1'b0);
    check("rst_rf_re", o_rf_re, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Single read, hazard, x0, rs2 hazard, same-cycle write/read.
    for (int r = 0; r < 17; r++) begin
      i_rd_valid = tbl[r].rv; i_rd_rs1 = tbl[r].rs1; i_rd_rs2 = tbl[r].rs2;
      i_wb_valid = tbl[r].wv; i_wb_rd = tbl[r].wrd; i_wb_value = tbl[r].wval;
      sample();
      check($sformatf("v%0d_rd_ready", r), o_rd_ready, tbl[r].e_rdy);
      check($sformatf("v%0d_rf_re", r), o_rf_re, tbl[r].e_rdy);
      check($sformatf("v%0d_rf_we", r), o_rf_we, tbl[r].e_we);
      check($sformatf("v%0d_wb_ready", r), o_wb_ready, 1'b1);
      check($sformatf("v%0d_rsp_valid", r), o_rsp_valid, tbl[r].e_rsp);
      check($sformatf("v%0d_busy", r), o_busy, tbl[r].e_busy);
      if (tbl[r].e_we) begin
        check($sformatf("v%0d_waddr", r), o_rf_waddr, tbl[r].e_waddr);
        check($sformatf("v%0d_wdata", r), o_rf_wdata, tbl[r].e_wdata);
      end
      if (tbl[r].e_rdy) begin
        check($sformatf("v%0d_raddr1", r), o_rf_raddr1, tbl[r].rs1);
        check($sformatf("v%0d_raddr2", r), o_rf_raddr2, tbl[r].rs2);
      end
      if (tbl[r].e_rsp) begin
        check($sformatf("v%0d_rsp1", r), o_rsp_rs1_value, tbl[r].e_r1);
        check($sformatf("v%0d_rsp2", r), o_rsp_rs2_value, tbl[r].e_r2);
      end
      @(negedge i_clk);
    end

    // Streak bound and FIFO fill: full after cycle 12, ready low in cycle 13,
    // then pop and push together in cycles 14/15.
    stream(17, 13);

    // Drain four queued entries in acceptance order.
    idle_inputs();
    for (int d = 0; d < 5; d++) begin
      sample();
      check($sformatf("drain_we[%0d]", d), o_rf_we, d < 4);
      check($sformatf("drain_busy[%0d]", d), o_busy, d < 4);
      if (d == 0) begin
        check("drain_full_ready", o_wb_ready, 1'b0);
        check("drain_rsp_valid", o_rsp_valid, 1'b1);
        check("drain_rsp1", o_rsp_rs1_value, 64'h107);
      end
      if (d == 4) check("drain_ready", o_wb_ready, 1'b1);
      @(negedge i_clk);
    end
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Async reset with two entries queued and a response pending.
    stream(5, -1);
    i_rd_valid = 1'b1; i_rd_rs1 = 5'd7; i_rd_rs2 = 5'd8;
    i_wb_valid = 1'b1; i_wb_rd = 5'(rds[push_k % 8]); i_wb_value = 64'hC0DE_0000 + 64'(push_k);
    sample();
    check("pre_rst_rsp_valid", o_rsp_valid, 1'b1);
    check("pre_rst_busy", o_busy, 1'b1);
    i_rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", o_rsp_valid, 1'b0);
    check("arst_rsp1", o_rsp_rs1_value, 64'h0);
    check("arst_busy", o_busy, 1'b0);
    check("arst_wb_ready", o_wb_ready, 1'b0);
    check("arst_rd_ready", o_rd_ready, 1'b0);
    check("arst_rf_we", o_rf_we, 1'b0);
    check("arst_rf_re", o_rf_re, 1'b0);
    sb.delete();
    idle_inputs();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    for (int p = 0; p < 4; p++) begin
      sample();
      check($sformatf("post_rst_we[%0d]", p), o_rf_we, 1'b0);
      check($sformatf("post_rst_busy[%0d]", p), o_busy, 1'b0);
      check($sformatf("post_rst_rsp[%0d]", p), o_rsp_valid, 1'b0);
      check($sformatf("post_rst_ready[%0d]", p), o_wb_ready, 1'b1);
      @(negedge i_clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
